// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: SimpleRisc opcode encodings, instruction field positions
// and the divider FSM state type shared by the execute stage.
package simplerisc_pkg;
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int IBIT    = 26;
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_MOD  = 5'b00100;
   localparam logic [4:0] OP_CMP  = 5'b00101;
   localparam logic [4:0] OP_AND  = 5'b00110;
   localparam logic [4:0] OP_OR   = 5'b00111;
   localparam logic [4:0] OP_NOT  = 5'b01000;
   localparam logic [4:0] OP_MOV  = 5'b01001;
   localparam logic [4:0] OP_LSL  = 5'b01010;
   localparam logic [4:0] OP_LSR  = 5'b01011;
   localparam logic [4:0] OP_ASR  = 5'b01100;
   localparam logic [4:0] OP_NOP  = 5'b01101;
   localparam logic [4:0] OP_LD   = 5'b01110;
   localparam logic [4:0] OP_ST   = 5'b01111;
   localparam logic [4:0] OP_BEQ  = 5'b10000;
   localparam logic [4:0] OP_BGT  = 5'b10001;
   localparam logic [4:0] OP_B    = 5'b10010;
   localparam logic [4:0] OP_CALL = 5'b10011;
   localparam logic [4:0] OP_RET  = 5'b10100;
   typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_e;
endpackage

// File: rtl/iter_divider.sv
// iter_divider: signed restoring divider, one quotient bit per cycle; the
// quotient/remainder outputs are valid in the cycle done is high.
module iter_divider
   import simplerisc_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);
   localparam int CW = $clog2(W);
   div_state_e state, state_n;
   logic [CW-1:0] count;
   logic [W-1:0] rem, quo, den, rem_n, quo_n;
   logic [W:0] trial;
   logic neg_q, neg_r, dz;
   assign busy = state == DIV_BUSY;
   assign done = busy & (count == '0);
   assign trial = {rem, quo[W-1]} - {1'b0, den};
   assign rem_n = trial[W] ? {rem[W-2:0], quo[W-1]} : trial[W-1:0];
   assign quo_n = {quo[W-2:0], ~trial[W]};
   // Magnitudes are divided, signs reapplied; INT_MIN/-1 falls out naturally.
   assign quotient = dz ? '1 : (neg_q ? -quo_n : quo_n);
   assign remainder = neg_r ? -rem_n : rem_n;
   always_comb begin
      state_n = state;
      if (state == DIV_IDLE && start) state_n = DIV_BUSY;
      else if (done) state_n = DIV_IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DIV_IDLE;
         count <= '0;
      end else begin
         state <= state_n;
         count <= (start && !busy) ? CW'(W - 1) : (busy ? count - CW'(1) : count);
      end
   end
   always_ff @(posedge clk) begin
      if (start && !busy) begin
         rem   <= '0;
         quo   <= dividend[W-1] ? -dividend : dividend;
         den   <= divisor[W-1] ? -divisor : divisor;
         neg_q <= dividend[W-1] ^ divisor[W-1];
         neg_r <= dividend[W-1];
         dz    <= divisor == '0;
      end else if (busy) begin
         rem <= rem_n;
         quo <= quo_n;
      end
   end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: SimpleRisc execute stage - ALU, branch resolution, flags and the
// EX/MA latch, with an iterative divider that stalls the upstream stages.
module ex_stage
   import simplerisc_pkg::*;
#(
   parameter int PC_W = 10,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [PC_W-1:0] in_pc,
   input  logic [31:0]     in_ir,
   input  logic [XLEN-1:0] in_branch_target,
   input  logic [XLEN-1:0] in_op_a,
   input  logic [XLEN-1:0] in_op_b,
   input  logic [XLEN-1:0] in_op_2,
   output logic            stall,
   output logic            is_branch_taken,
   output logic [PC_W-1:0] branch_pc,
   output logic            out_valid,
   output logic [PC_W-1:0] out_pc,
   output logic [31:0]     out_ir,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] out_op_2,
   output logic            flag_e,
   output logic            flag_gt
);
   logic [4:0] op, sh;
   logic accept, is_divmod, start, op_ok, div_busy, div_done, unused_bits;
   logic [XLEN-1:0] res, quo, rem;
   logic [PC_W-1:0] div_pc;
   logic [31:0] div_ir;
   assign op = in_ir[OPC_MSB:OPC_LSB];
   assign sh = in_op_b[4:0];
   assign accept = in_valid & ~div_busy;
   assign is_divmod = (op == OP_DIV) | (op == OP_MOD);
   assign start = accept & is_divmod;
   assign op_ok = (op <= OP_RET) & (op != OP_NOP);
   assign stall = start | (div_busy & ~div_done);
   assign is_branch_taken = accept & ((op == OP_B) | (op == OP_CALL) | (op == OP_RET) |
                                      ((op == OP_BEQ) & flag_e) | ((op == OP_BGT) & flag_gt));
   assign branch_pc = (op == OP_RET) ? in_op_a[PC_W-1:0] : in_branch_target[PC_W-1:0];
   assign unused_bits = ^in_branch_target[XLEN-1:PC_W];
   iter_divider #(.W(XLEN)) u_div (
      .clk(clk), .reset(reset), .start(start), .dividend(in_op_a), .divisor(in_op_b),
      .busy(div_busy), .done(div_done), .quotient(quo), .remainder(rem)
   );
   always_comb begin
      res = '0;
      case (op)
         OP_ADD, OP_LD, OP_ST: res = in_op_a + in_op_b;
         OP_SUB:  res = in_op_a - in_op_b;
         OP_MUL:  res = in_op_a * in_op_b;
         OP_AND:  res = in_op_a & in_op_b;
         OP_OR:   res = in_op_a | in_op_b;
         OP_NOT:  res = ~in_op_b;
         OP_MOV:  res = in_op_b;
         OP_LSL:  res = in_op_a << sh;
         OP_LSR:  res = in_op_a >> sh;
         OP_ASR:  res = XLEN'($signed(in_op_a) >>> sh);
         OP_CALL: res = XLEN'(in_pc + PC_W'(4));
         default: res = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_pc     <= '0;
         out_ir     <= '0;
         alu_result <= '0;
         out_op_2   <= '0;
         flag_e     <= 1'b0;
         flag_gt    <= 1'b0;
      end else if (div_done) begin
         out_valid  <= 1'b1;
         out_pc     <= div_pc;
         out_ir     <= div_ir;
         alu_result <= (div_ir[OPC_MSB:OPC_LSB] == OP_MOD) ? rem : quo;
         out_op_2   <= '0;
      end else if (accept && !is_divmod) begin
         out_valid  <= op_ok;
         out_pc     <= in_pc;
         out_ir     <= in_ir;
         alu_result <= res;
         out_op_2   <= in_op_2;
         if (op == OP_CMP) begin
            flag_e  <= in_op_a == in_op_b;
            flag_gt <= $signed(in_op_a) > $signed(in_op_b);
         end
      end else begin
         out_valid <= 1'b0;
      end
   end
   // The divide's pc/ir ride alongside the divider until its result is written.
   always_ff @(posedge clk) begin
      if (start) begin
         div_pc <= in_pc;
         div_ir <= in_ir;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage; stimulus pushes expected EX/MA
// entries computed by a behavioural model, a monitor pops and compares them.
module tb_ex_stage;
   import simplerisc_pkg::*;
   localparam int PC_W = 10;
   localparam int XLEN = 32;
   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
   logic [PC_W-1:0] in_pc = '0, branch_pc, out_pc;
   logic [31:0] in_ir = '0, out_ir;
   logic [XLEN-1:0] in_branch_target = '0, in_op_a = '0, in_op_b = '0, in_op_2 = '0;
   logic [XLEN-1:0] alu_result, out_op_2;
   logic stall, is_branch_taken, out_valid, flag_e, flag_gt;
   ex_stage #(.PC_W(PC_W), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_ir(in_ir),
      .in_branch_target(in_branch_target), .in_op_a(in_op_a), .in_op_b(in_op_b),
      .in_op_2(in_op_2), .stall(stall), .is_branch_taken(is_branch_taken),
      .branch_pc(branch_pc), .out_valid(out_valid), .out_pc(out_pc), .out_ir(out_ir),
      .alu_result(alu_result), .out_op_2(out_op_2), .flag_e(flag_e), .flag_gt(flag_gt)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [PC_W-1:0] pc;
      logic [31:0] ir;
      logic [31:0] res;
      logic [31:0] op2;
      bit chk_op2;
      int cyc;
   } exp_t;
   exp_t sb[$];
   int tests = 0, fails = 0, cyc = 0;
   bit fe_m = 0, fg_m = 0;
   logic [31:0] specials [4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask
   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [PC_W-1:0] pc);
      int sa, sbv;
      sa = a;
      sbv = b;
      case (op)
         OP_ADD, OP_LD, OP_ST: return a + b;
         OP_SUB: return a - b;
         OP_MUL: return sa * sbv;
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sbv;
         end
         OP_MOD: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return sa % sbv;
         end
         OP_AND: return a & b;
         OP_OR:  return a | b;
         OP_NOT: return ~b;
         OP_MOV: return b;
         OP_LSL: return a << b[4:0];
         OP_LSR: return a >> b[4:0];
         OP_ASR: return sa >>> b[4:0];
         OP_CALL: return (int'(pc) + 4) % (1 << PC_W);
         default: return 0;
      endcase
   endfunction
   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 3))
         0: return $urandom_range(0, 15);
         1: return -$urandom_range(1, 15);
         2: return $urandom;
         default: return specials[$urandom_range(0, 3)];
      endcase
   endfunction
   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask
   // Called just after a posedge; returns just after the posedge that consumes it.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] o2, input logic [31:0] tgt,
                        input logic [PC_W-1:0] pc, input string tag);
      exp_t e;
      int n;
      bit tk, dm;
      logic [PC_W-1:0] bpc;
      in_valid = 1'b1;
      in_ir = {op, 27'($urandom)};
      in_pc = pc;
      in_op_a = a;
      in_op_b = b;
      in_op_2 = o2;
      in_branch_target = tgt;
      dm = (op == OP_DIV) || (op == OP_MOD);
      tk = (op == OP_B) || (op == OP_CALL) || (op == OP_RET) ||
           (op == OP_BEQ && fe_m) || (op == OP_BGT && fg_m);
      bpc = (op == OP_RET) ? a[PC_W-1:0] : tgt[PC_W-1:0];
      #1;
      check({tag, " is_branch_taken"}, is_branch_taken, tk);
      if (tk) check({tag, " branch_pc"}, branch_pc, bpc);
      if (op == OP_CMP) begin
         fe_m = a == b;
         fg_m = $signed(a) > $signed(b);
      end
      if (op <= OP_RET && op != OP_NOP) begin
         e.pc = pc;
         e.ir = in_ir;
         e.res = model(op, a, b, pc);
         e.op2 = o2;
         e.chk_op2 = (op == OP_LD) || (op == OP_ST);
         e.cyc = cyc + (dm ? 33 : 1);
         sb.push_back(e);
      end
      n = 0;
      while (stall && n < 40) begin
         n++;
         @(posedge clk);
         #1;
      end
      check({tag, " stall cycles"}, n, dm ? 32 : 0);
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected out_valid: got 1 expected 0 (out_pc %h)", out_pc);
         end else begin
            e = sb.pop_front();
            check("out cycle", cyc, e.cyc);
            check("out_pc", out_pc, e.pc);
            check("out_ir", out_ir, e.ir);
            check("alu_result", alu_result, e.res);
            if (e.chk_op2) check("out_op_2", out_op_2, e.op2);
         end
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset alu_result", alu_result, 0);
      check("reset out_pc", out_pc, 0);
      check("reset out_ir", out_ir, 0);
      check("reset out_op_2", out_op_2, 0);
      check("reset flags", {flag_e, flag_gt}, 0);
      check("reset stall", stall, 0);
      reset = 1'b0;
      idle(1);
      issue(OP_ADD, 5, 7, 0, 0, 10'h000, "add");
      issue(OP_CMP, 3, 3, 0, 0, 10'h004, "cmp33");
      issue(OP_BEQ, 0, 0, 0, 32'h040, 10'h008, "beq eq");
      issue(OP_CMP, 5, 3, 0, 0, 10'h00C, "cmp53");
      issue(OP_BEQ, 0, 0, 0, 32'h080, 10'h010, "beq ne");
      issue(OP_BGT, 0, 0, 0, 32'h0C0, 10'h014, "bgt");
      issue(OP_DIV, -7, 2, 0, 0, 10'h018, "div -7/2");
      issue(OP_MOD, -7, 2, 0, 0, 10'h01C, "mod -7,2");
      issue(OP_DIV, 10, 0, 0, 0, 10'h020, "div 10/0");
      issue(OP_MOD, 10, 0, 0, 0, 10'h024, "mod 10,0");
      issue(OP_DIV, 32'h8000_0000, -1, 0, 0, 10'h028, "div min/-1");
      issue(OP_MOD, 32'h8000_0000, -1, 0, 0, 10'h02C, "mod min/-1");
      issue(OP_ST, 32'h100, 8, 32'hCAFE_F00D, 0, 10'h030, "st");
      issue(OP_CALL, 0, 0, 0, 32'h100, 10'h010, "call");
      issue(OP_RET, 32'h14, 0, 0, 0, 10'h100, "ret");
      issue(OP_NOP, 1, 2, 0, 0, 10'h014, "nop");
      check("nop bubble", out_valid, 0);
      issue(OP_CMP, 9, 9, 0, 0, 10'h018, "cmp99");
      in_valid = 1'b1;
      in_ir = {OP_DIV, 27'd0};
      in_op_a = 100;
      in_op_b = 7;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      fe_m = 0;
      fg_m = 0;
      check("abort stall", stall, 0);
      check("abort out_valid", out_valid, 0);
      check("abort flags", {flag_e, flag_gt}, 0);
      idle(2);
      check("abort quiet", {stall, out_valid}, 0);
      issue(OP_ADD, 1, 1, 0, 0, 10'h040, "add after abort");
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
         issue(5'($urandom_range(0, 31)), rnd_val(), rnd_val(), $urandom, $urandom,
               10'($urandom), "rand");
      end
      idle(3);
      check("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the SimpleRisc 5-stage pipeline. It consumes the OF/EX latch outputs (PC, IR, branch target, operands) and computes the ALU result. It resolves branches against the flags register and signals taken branches to IF, which drives the predict-not-taken flush. Div/mod run in an iterative divider that stalls upstream stages; the result goes to the EX/MA latch.

Parameters:
PC_W, 10, PC width (byte address)
XLEN, 32, datapath width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
in_valid  in  1  OF/EX latch holds a real instruction
in_pc  in  PC_W  instruction PC
in_ir  in  32  instruction; opcode = ir[31:27], I-bit = ir[26]
in_branch_target  in  XLEN  PC-relative target computed in OF
in_op_a  in  XLEN  rs1 value (ra for ret)
in_op_b  in  XLEN  second operand, already muxed reg/immediate in OF
in_op_2  in  XLEN  store data (rd value for st)
stall  out  1  hold IF, IF/OF and OF/EX latches
is_branch_taken  out  1  combinational; flush IF/OF and OF/EX, redirect IF
branch_pc  out  PC_W  combinational redirect target
out_valid  out  1  registered; EX/MA entry valid
out_pc  out  PC_W  registered
out_ir  out  32  registered
alu_result  out  XLEN  registered
out_op_2  out  XLEN  registered store data
flag_e, flag_gt  out  1 each  flags register

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Reset: out_valid=0; out_pc, out_ir, alu_result, out_op_2=0; flags=0; divider FSM=IDLE; stall=0.
- Accept: the instruction is consumed when in_valid & FSM==IDLE. Inputs presented while BUSY are ignored; stall keeps the upstream latches holding.
- Single-cycle ops give their result on the next posedge (latency 1): add, sub, mul (low 32 bits of the signed product), and, or, not (~op_b), mov (op_b), lsl, lsr, asr (shift amount = op_b[4:0]). Arithmetic is mod 2^32 with no traps.
- cmp: flag_e = (a==b); flag_gt = signed(a)>signed(b). Flags update at the posedge that ends the cmp cycle. An immediately following beq/bgt sees the new flags, so no forwarding is needed.
- ld/st: alu_result = a+b (address); out_op_2 = in_op_2.
- Branches, evaluated combinationally in the accept cycle:
  - b and call: always taken.
  - beq: taken iff flag_e. bgt: taken iff flag_gt.
  - ret: taken, branch_pc = in_op_a[PC_W-1:0].
  - Other taken branches: branch_pc = in_branch_target[PC_W-1:0].
  - call: alu_result = in_pc+4, zero-extended.
  - is_branch_taken = 0 whenever in_valid=0 or FSM!=IDLE.
- nop or undefined opcode: out_valid=0 for that slot, flags unchanged. Any other accepted instruction gives out_valid=1. No accept gives out_valid=0 (bubble).
- div/mod, signed:
  - Divide the magnitudes with a restoring divider, one bit per cycle over 32 iterations.
  - Quotient is negative iff operand signs differ. The remainder takes the sign of the dividend.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - INT_MIN/-1: quotient 0x80000000, remainder 0.
- Divider FSM:
  - IDLE: on accepting div/mod in cycle 0, latch operands, pc and ir; go to BUSY with count=31.
  - BUSY: one iteration per cycle; count decrements.
  - Final iteration (count==0) in cycle 32: returns to IDLE; out_* written with out_valid=1 in cycle 33.
  - stall = (IDLE & in_valid & is_divmod) | (BUSY & count!=0). Stall is high in cycles 0–31 and low in cycle 32, so OF/EX advances on the same edge the result is written.
  - During BUSY with count!=0, out_valid=0.
- Reset mid-divide: the operation is aborted, with FSM=IDLE, stall=0 and out_valid=0 in the next cycle. Nothing is written.
- A taken branch and a divide cannot coexist in one accept, since the opcodes are exclusive.

Decomposition:
- simplerisc_pkg: 5-bit opcode constants (ADD=00000 … RET=10100), opcode/I-bit field positions, FSM state encoding.
- Sub-module iter_divider: signed restoring divider with start/busy/done, outputs quotient and remainder.
- ex_stage holds the ALU, branch unit, flags, output register and stall logic.

Test Plan:
- add a=5, b=7, in_valid=1 -> next cycle out_valid=1, alu_result=12; stall stays 0.
- cmp 3,3 then beq target 0x040 -> beq cycle: is_branch_taken=1, branch_pc=0x040. cmp 5,3 then beq -> not taken; bgt -> taken.
- div a=-7, b=2 -> stall high 32 cycles, then alu_result=0xFFFFFFFD. mod -7,2 -> 0xFFFFFFFF. Inputs held during stall are not re-executed.
- div 10/0 -> 0xFFFFFFFF; mod 10,0 -> 10. div 0x80000000/-1 -> 0x80000000.
- reset during divider iteration 10 -> next cycle stall=0, out_valid=0, flags=0. A following add 1+1 gives 2.
- call at pc 0x010, target 0x100 -> is_branch_taken=1, branch_pc=0x100, alu_result=0x14. Then ret with a=0x14 -> branch_pc=0x014. nop -> out_valid=0.
